fpmult_arbiter: RTL and testbench
=================================

FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, means cycles from operand launch on mul_a/mul_b to result sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-006 req0_ready  output  1  requester 0 handshake accept.
REQ-007 req1_valid  input  1  requester 1 has an operation pending.
REQ-008 req1_a, req1_b  input  32 each  requester 1 operands.
REQ-009 req1_ready  output  1  requester 1 handshake accept.
REQ-010 resp0_valid, resp1_valid  output  1 each  one-cycle result strobe to the owning requester.
REQ-011 resp_data  output  32  product; resp_ovf, resp_unf  output  1 each  overflow/underflow flags.
REQ-012 mul_a, mul_b  output  32 each  operands to the shared combinational FP multiplier.
REQ-013 mul_out  input  32; mul_ovf, mul_unf  input  1 each  multiplier result and flags.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; encoding is free.
REQ-016 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester, and only when that requester's valid is high.
REQ-017 Grant: one valid -> that requester; both valid -> requester not granted last (round-robin); last-grant pointer updates only on a handshake.
REQ-018 Handshake (valid & ready, cycle T) SHALL register both operands into mul_a/mul_b, record owner, load the 4-bit counter with LATENCY and move to WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle; at the end of the cycle where the counter is 1 (cycle T+LATENCY), mul_out/mul_ovf/mul_unf are registered and the FSM moves to RESP.
REQ-020 In RESP (cycle T+LATENCY+1), the owner's respN_valid SHALL be high for exactly one cycle with registered resp_data/resp_ovf/resp_unf; the other respN_valid stays low; next state IDLE.
REQ-021 No ready SHALL assert in WAIT or RESP; earliest next handshake is cycle T+LATENCY+2.
REQ-022 Requesters SHALL hold valid and operands stable until ready; deasserting valid before ready is legal and withdraws the request without effect.
REQ-023 mul_a/mul_b SHALL hold the last launched operands in IDLE and change only on a handshake.
REQ-024 resp_data/resp_ovf/resp_unf SHALL hold their last value outside RESP.

Reset
REQ-025 Reset SHALL force IDLE with all ready/resp_valid/busy low, mul_a/mul_b/resp_data = 0, flags = 0, counter = 0, and last-grant pointer = requester 1 so requester 0 wins the first tie.
REQ-026 Reset asserted in WAIT or RESP SHALL abort the operation; no respN_valid is issued for it after release.

Verification
REQ-027 Single op, LATENCY=1: req0 0x40000000 x 0x40400000 handshake cycle T -> resp0_valid at T+2, resp_data 0x40C00000, flags 0, resp1_valid low.
REQ-028 Tie after reset: both valid same cycle -> req0 granted first, then req1 at T+LATENCY+2; with both held valid, grants alternate 0,1,0,1.
REQ-029 LATENCY=4: handshake at T -> mul_a/mul_b stable T+1..T+4, busy high T+1..T+5, resp strobe at T+5 only.
REQ-030 Flags: model returns mul_ovf=1 with 0x7F800000 -> resp_ovf=1, resp_data 0x7F800000 on owner's strobe.
REQ-031 Reset mid-WAIT: assert reset at T+1 with LATENCY=3 -> outputs at reset values immediately, no resp strobe after release, next request served normally.
REQ-032 Withdrawn request: req1_valid pulses one cycle while busy -> never granted, no resp1_valid.

Source files
------------

// File: rtl/fpmult_arbiter.sv
// Two-requester round-robin front end for one shared combinational FP multiplier.
// An operation launches on a handshake, waits LATENCY cycles, then returns its result to the owner.
module fpmult_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        resp_ovf,
  output logic        resp_unf,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  input  logic        mul_ovf,
  input  logic        mul_unf,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  // Handshake: a request transfers in the cycle where reqN_valid and reqN_ready
  // are both high; ready is only ever offered in IDLE, to the granted requester.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       owner;
  logic       last_grant;
  logic       sel;
  logic       hs;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    if (req0_valid && req1_valid) sel = ~last_grant;
    else                          sel = req1_valid;
  end

  always_comb begin
    state_nx    = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = req0_valid && !sel;
        req1_ready = req1_valid && sel;
        if (req0_ready || req1_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_nx = S_RESP;
      end
      S_RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign hs        = req0_ready || req1_ready;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Operands stay parked on the multiplier inputs until the next launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a      <= '0;
      mul_b      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      resp_data  <= '0;
      resp_ovf   <= 1'b0;
      resp_unf   <= 1'b0;
    end else if (hs) begin
      mul_a      <= sel ? req1_a : req0_a;
      mul_b      <= sel ? req1_b : req0_b;
      owner      <= sel;
      last_grant <= sel;
      cnt        <= 4'(LATENCY);
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        resp_data <= mul_out;
        resp_ovf  <= mul_ovf;
        resp_unf  <= mul_unf;
      end
    end
  end

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Randomized bench for fpmult_arbiter at LATENCY 1, 3 and 4 against a
// timestamp-based reference model of grants, busy windows and result strobes.
module tb_fpmult_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v0 [3], v1 [3];
  logic [31:0] a0 [3], b0 [3], a1 [3], b1 [3];
  logic        r0 [3], r1 [3], rv0 [3], rv1 [3];
  logic        ovf [3], unf [3], bsy [3];
  logic [31:0] rd [3], ma [3], mb [3], mo [3];
  logic        mov [3], mun [3];
  logic [1:0]  st [3];

  // Stand-in multiplier: exact for 2.0 x 3.0, otherwise exponent-add with flags.
  function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [9:0] e;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return {2'b00, 32'h40C0_0000};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    if (e > 10'd381) return {2'b10, a[31] ^ b[31], 8'hFF, 23'd0};
    if (e < 10'd128) return {2'b01, a[31] ^ b[31], 31'd0};
    e = e - 10'd127;
    return {2'b00, a[31] ^ b[31], e[7:0], a[22:0] ^ b[22:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    fpmult_arbiter #(.LATENCY(L)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(v0[g]), .req0_a(a0[g]), .req0_b(b0[g]), .req0_ready(r0[g]),
      .req1_valid(v1[g]), .req1_a(a1[g]), .req1_b(b1[g]), .req1_ready(r1[g]),
      .resp0_valid(rv0[g]), .resp1_valid(rv1[g]),
      .resp_data(rd[g]), .resp_ovf(ovf[g]), .resp_unf(unf[g]),
      .mul_a(ma[g]), .mul_b(mb[g]),
      .mul_out(mo[g]), .mul_ovf(mov[g]), .mul_unf(mun[g]),
      .busy(bsy[g]), .fsm_state(st[g])
    );
    assign {mov[g], mun[g], mo[g]} = fmul(ma[g], mb[g]);
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        own;
    logic        ovf;
    logic        unf;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          free_at = 0;
  int          act = 0;
  int          lat = 1;
  logic        m_last;
  logic [31:0] m_ma, m_mb, m_rd;
  logic        m_ovf, m_unf;
  logic        hs0, hs1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", tag, act, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 1) r[30:23] = 8'($urandom_range(100, 160));
    return r;
  endfunction

  task automatic zero_inputs();
    for (int k = 0; k < 3; k++) begin
      v0[k] = 1'b0; v1[k] = 1'b0;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    free_at = cyc;
    m_last  = 1'b1;
    m_ma = '0; m_mb = '0; m_rd = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    hs0 = 1'b0; hs1 = 1'b0;
  endtask

  // Called #1 after a rising edge with this cycle's inputs already applied.
  task automatic step();
    logic  idle, e0, e1, er0, er1;
    exp_t  e;
    logic [33:0] p;
    @(negedge clk);
    idle = (cyc >= free_at);
    e0 = idle && v0[act] && (!v1[act] || m_last);
    e1 = idle && v1[act] && (!v0[act] || !m_last);
    check("ready0", r0[act], e0);
    check("ready1", r1[act], e1);
    check("busy", bsy[act], !idle);
    check("mul_a", ma[act], m_ma);
    check("mul_b", mb[act], m_mb);
    er0 = 1'b0; er1 = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
      e = exp_q.pop_front();
      er0 = !e.own; er1 = e.own;
      m_rd = e.data; m_ovf = e.ovf; m_unf = e.unf;
    end
    check("resp0_valid", rv0[act], er0);
    check("resp1_valid", rv1[act], er1);
    check("resp_data", rd[act], m_rd);
    check("resp_ovf", ovf[act], m_ovf);
    check("resp_unf", unf[act], m_unf);
    hs0 = e0; hs1 = e1;
    if (e0 || e1) begin
      m_ma = e1 ? a1[act] : a0[act];
      m_mb = e1 ? b1[act] : b0[act];
      p = fmul(m_ma, m_mb);
      exp_q.push_back('{cyc: 32'(cyc + lat + 1), own: e1, ovf: p[33], unf: p[32], data: p[31:0]});
      m_last  = e1;
      free_at = cyc + lat + 2;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // mode 0: random raise/withdraw; mode 1: both requesters always valid.
  task automatic drive(input int mode);
    if (hs0 || !v0[act]) begin
      if (mode == 1 || $urandom_range(0, 9) < 4) begin
        v0[act] = 1'b1; a0[act] = rand_op(); b0[act] = rand_op();
      end else v0[act] = 1'b0;
    end else if (mode == 0 && $urandom_range(0, 7) == 0) v0[act] = 1'b0;
    if (hs1 || !v1[act]) begin
      if (mode == 1 || $urandom_range(0, 9) < 4) begin
        v1[act] = 1'b1; a1[act] = rand_op(); b1[act] = rand_op();
      end else v1[act] = 1'b0;
    end else if (mode == 0 && $urandom_range(0, 7) == 0) v1[act] = 1'b0;
  endtask

  // Asserts reset now, checks reset values on every instance, releases a cycle later.
  task automatic do_reset();
    reset = 1'b1;
    zero_inputs();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", bsy[k], 1'b0);
      check("rst_ready", {r1[k], r0[k]}, 2'b00);
      check("rst_resp_valid", {rv1[k], rv0[k]}, 2'b00);
      check("rst_mul_a", ma[k], 32'h0);
      check("rst_mul_b", mb[k], 32'h0);
      check("rst_resp_data", rd[k], 32'h0);
      check("rst_flags", {ovf[k], unf[k]}, 2'b00);
    end
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic select(input int k);
    act = k;
    lat = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    zero_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // 2.0 x 3.0 on requester 0 at LATENCY 1.
    select(0);
    v0[0] = 1'b1; a0[0] = 32'h4000_0000; b0[0] = 32'h4040_0000;
    step();
    v0[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("single_result", m_rd, 32'h40C0_0000);

    // Tie from reset with both held valid: grants alternate 0,1,0,1.
    select(0);
    for (int i = 0; i < 14; i++) begin drive(1); step(); end
    select(2);
    for (int i = 0; i < 20; i++) begin drive(1); step(); end

    // Overflow flag on requester 1 at LATENCY 3.
    select(1);
    v1[1] = 1'b1; a1[1] = 32'h7F00_0000; b1[1] = 32'h7F00_0000;
    step();
    v1[1] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("ovf_result", {31'd0, m_ovf}, 32'd1);

    // Reset one cycle after launch at LATENCY 3, then a normal operation.
    v0[1] = 1'b1; a0[1] = rand_op(); b0[1] = rand_op();
    step();
    v0[1] = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    v0[1] = 1'b1; a0[1] = 32'h4000_0000; b0[1] = 32'h4040_0000;
    step();
    v0[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Requester 1 pulses valid for one cycle while busy.
    select(0);
    v0[0] = 1'b1; a0[0] = rand_op(); b0[0] = rand_op();
    step();
    v0[0] = 1'b0; v1[0] = 1'b1; a1[0] = rand_op(); b1[0] = rand_op();
    step();
    v1[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Random traffic on each latency.
    for (int k = 0; k < 3; k++) begin
      select(k);
      for (int i = 0; i < 300; i++) begin drive(0); step(); end
      zero_inputs();
      for (int i = 0; i < 8; i++) step();
      check("drained", exp_q.size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
